// File: rtl/axi_mem_slave_if.sv
// AXI4 bus bundle between a master (cache AXI driver) and the memory responder.
// Signal names follow the AXI channel names, lower-cased and without the S_AXI_ prefix.
interface axi_mem_slave_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4
);
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [AXI_ID_WIDTH-1:0]     awid;
    logic [7:0]                  awlen;
    logic [2:0]                  awsize;
    logic [1:0]                  awburst;
    logic                        awvalid;
    logic                        awready;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wlast;
    logic                        wvalid;
    logic                        wready;
    logic [AXI_ID_WIDTH-1:0]     bid;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic [AXI_ID_WIDTH-1:0]     arid;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    logic                        arvalid;
    logic                        arready;
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [AXI_ID_WIDTH-1:0]     rid;
    logic [1:0]                  rresp;
    logic                        rlast;
    logic                        rvalid;
    logic                        rready;

    modport master (
        output awaddr, awid, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output araddr, arid, arlen, arsize, arburst, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rdata, rid, rresp, rlast, rvalid
    );

    modport slave (
        input  awaddr, awid, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  araddr, arid, arlen, arsize, arburst, arvalid, rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rdata, rid, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 memory responder: word-addressed on-chip RAM with independent write and read FSMs.
//
// state  | meaning
// W_IDLE | waiting for AW (AWREADY=1)
// W_DATA | accepting W beats until LEN+1 beats seen
// W_RESP | BVALID held until BREADY
// R_IDLE | waiting for AR (ARREADY=1)
// R_DATA | RVALID=1, presenting beats until the last handshake
module axi_mem_slave #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MEM_DEPTH      = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    axi_mem_slave_if.slave     s_axi
);
    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int IDXW  = $clog2(MEM_DEPTH);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_t                  w_state_q, w_state_d;
    logic [AXI_ID_WIDTH-1:0]   w_id_q, w_id_d;
    logic [IDXW-1:0]           w_idx_q, w_idx_d;
    logic [7:0]                w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [1:0]                w_burst_q, w_burst_d;
    logic                      w_err_q, w_err_d, w_skip_q, w_skip_d;
    logic                      mem_we;

    r_state_t                  r_state_q, r_state_d;
    logic [AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [IDXW-1:0]           r_idx_q, r_idx_d;
    logic [7:0]                r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [1:0]                r_burst_q, r_burst_d;
    logic                      r_bad_q, r_bad_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      rlast_q, rlast_d;
    logic [1:0]                rresp_q, rresp_d;

    // Holds both READYs low during reset; they rise on the first edge after release.
    logic                      rdy_q;
    logic                      aw_ok, ar_ok;
    logic                      unused_addr_bits;

    assign aw_ok = (s_axi.awburst == BURST_FIXED || s_axi.awburst == BURST_INCR) &&
                   (s_axi.awsize == 3'(LB));
    assign ar_ok = (s_axi.arburst == BURST_FIXED || s_axi.arburst == BURST_INCR) &&
                   (s_axi.arsize == 3'(LB));
    assign unused_addr_bits = ^{s_axi.awaddr, s_axi.araddr};

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        w_skip_d  = w_skip_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: if (rdy_q && s_axi.awvalid) begin
                w_id_d    = s_axi.awid;
                w_idx_d   = s_axi.awaddr[LB +: IDXW];
                w_len_d   = s_axi.awlen;
                w_burst_d = s_axi.awburst;
                w_cnt_d   = 8'd0;
                w_err_d   = !aw_ok;
                w_skip_d  = !aw_ok;
                w_state_d = W_DATA;
            end
            W_DATA: if (s_axi.wvalid) begin
                mem_we = !w_skip_q;
                if (s_axi.wlast != (w_cnt_q == w_len_q)) w_err_d = 1'b1;
                if (w_cnt_q == w_len_q) begin
                    w_state_d = W_RESP;
                end else begin
                    w_cnt_d = w_cnt_q + 8'd1;
                    if (w_burst_q == BURST_INCR) w_idx_d = w_idx_q + 1'b1;
                end
            end
            W_RESP: if (s_axi.bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    assign s_axi.awready = rdy_q && (w_state_q == W_IDLE);
    assign s_axi.wready  = (w_state_q == W_DATA);
    assign s_axi.bvalid  = (w_state_q == W_RESP);
    assign s_axi.bid     = w_id_q;
    assign s_axi.bresp   = (w_state_q == W_RESP && w_err_q) ? RESP_SLVERR : 2'b00;

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_burst_d = r_burst_q;
        r_bad_d   = r_bad_q;
        rdata_d   = rdata_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: if (rdy_q && s_axi.arvalid) begin
                r_id_d    = s_axi.arid;
                r_idx_d   = s_axi.araddr[LB +: IDXW];
                r_len_d   = s_axi.arlen;
                r_burst_d = s_axi.arburst;
                r_cnt_d   = 8'd0;
                r_bad_d   = !ar_ok;
                rdata_d   = ar_ok ? mem[r_idx_d] : '0;
                rlast_d   = (s_axi.arlen == 8'd0);
                rresp_d   = ar_ok ? 2'b00 : RESP_SLVERR;
                r_state_d = R_DATA;
            end
            R_DATA: if (s_axi.rready) begin
                if (r_cnt_q == r_len_q) begin
                    rlast_d   = 1'b0;
                    r_state_d = R_IDLE;
                end else begin
                    r_cnt_d = r_cnt_q + 8'd1;
                    if (r_burst_q == BURST_INCR) r_idx_d = r_idx_q + 1'b1;
                    rdata_d = r_bad_q ? '0 : mem[r_idx_d];
                    rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign s_axi.arready = rdy_q && (r_state_q == R_IDLE);
    assign s_axi.rvalid  = (r_state_q == R_DATA);
    assign s_axi.rid     = r_id_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rresp   = rresp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q     <= 1'b0;
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_burst_q <= '0;
            w_err_q   <= 1'b0;
            w_skip_q  <= 1'b0;
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_burst_q <= '0;
            r_bad_q   <= 1'b0;
            rdata_q   <= '0;
            rlast_q   <= 1'b0;
            rresp_q   <= '0;
        end else begin
            rdy_q     <= 1'b1;
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
            w_skip_q  <= w_skip_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_burst_q <= r_burst_d;
            r_bad_q   <= r_bad_d;
            rdata_q   <= rdata_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
        end
    end

    // Memory is not reset; a same-cycle read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++)
                if (s_axi.wstrb[b]) mem[w_idx_q][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
        end
    end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Self-checking bench for axi_mem_slave: write/read scoreboards fed by a byte-level memory model.
module tb_axi_mem_slave;
    localparam int AW = 32, DW = 64, IW = 4, DEPTH = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_mem_slave_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) bus ();

    axi_mem_slave #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
                    .MEM_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .s_axi(bus));

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [1:0]  resp;
        logic [3:0]  id;
    } r_exp_t;
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    r_exp_t      rq[$];
    b_exp_t      bq[$];
    logic [63:0] model [DEPTH];
    logic [63:0] wd [16];
    logic [7:0]  ws [16];
    int checks = 0;
    int errors = 0;

    task automatic init_bus();
        bus.awaddr = '0; bus.awid = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0; bus.wvalid = 0;
        bus.bready = 0; bus.araddr = '0; bus.arid = '0; bus.arlen = '0; bus.arsize = '0;
        bus.arburst = '0; bus.arvalid = 0; bus.rready = 0;
    endtask

    task automatic do_aw(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        bus.awaddr = addr; bus.awid = id; bus.awlen = len; bus.awburst = burst; bus.awsize = size;
        bus.awvalid = 1;
        while (!bus.awready && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL aw_timeout awready stayed 0 for %0d cycles, required 1", n); end
        @(negedge clk);
        bus.awvalid = 0;
    endtask

    task automatic do_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        bus.araddr = addr; bus.arid = id; bus.arlen = len; bus.arburst = burst; bus.arsize = size;
        bus.arvalid = 1;
        while (!bus.arready && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL ar_timeout arready stayed 0 for %0d cycles, required 1", n); end
        @(negedge clk);
        bus.arvalid = 0;
    endtask

    task automatic do_w(input logic [63:0] d, input logic [7:0] s, input logic last);
        int n = 0;
        bus.wdata = d; bus.wstrb = s; bus.wlast = last; bus.wvalid = 1;
        while (!bus.wready && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL w_timeout wready stayed 0 for %0d cycles, required 1", n); end
        @(negedge clk);
        bus.wvalid = 0;
    endtask

    function automatic void model_write(input int idx, input logic [63:0] d, input logic [7:0] s);
        for (int b = 0; b < 8; b++)
            if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    // early_last < 0: WLAST on the final beat; otherwise WLAST only on beat early_last.
    task automatic write_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                               input logic [1:0] burst, input logic [2:0] size, input int early_last);
        bit ok = (burst == 2'b00 || burst == 2'b01) && size == 3'd3;
        bit err = !ok;
        int idx = int'(addr[10:3]);
        logic last;
        do_aw(addr, id, len, burst, size);
        for (int i = 0; i <= int'(len); i++) begin
            last = (early_last >= 0) ? (i == early_last) : (i == int'(len));
            if (last != (i == int'(len))) err = 1;
            if (ok) model_write(idx, wd[i], ws[i]);
            do_w(wd[i], ws[i], last);
            if (burst == 2'b01) idx = (idx + 1) % DEPTH;
        end
        bq.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
    endtask

    task automatic collect_b(input int hold);
        int n = 0;
        b_exp_t e;
        while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL b_timeout bvalid stayed 0, required 1"); end
        e = bq.pop_front();
        for (int h = 0; h < hold; h++) begin
            checks++;
            if ({bus.bvalid, bus.bid, bus.bresp} !== {1'b1, e.id, e.resp}) begin
                errors++;
                $display("FAIL b_hold cycle %0d got valid=%b id=%h resp=%b, required valid=1 id=%h resp=%b",
                         h, bus.bvalid, bus.bid, bus.bresp, e.id, e.resp);
            end
            @(negedge clk);
        end
        checks++;
        if ({bus.bvalid, bus.bid, bus.bresp} !== {1'b1, e.id, e.resp}) begin
            errors++;
            $display("FAIL b_resp got valid=%b id=%h resp=%b, required valid=1 id=%h resp=%b",
                     bus.bvalid, bus.bid, bus.bresp, e.id, e.resp);
        end
        bus.bready = 1;
        @(negedge clk);
        bus.bready = 0;
    endtask

    task automatic push_r(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
        bit ok = (burst == 2'b00 || burst == 2'b01) && size == 3'd3;
        int idx = int'(addr[10:3]);
        for (int i = 0; i <= int'(len); i++) begin
            rq.push_back('{data: ok ? model[idx] : 64'h0, last: (i == int'(len)),
                           resp: ok ? 2'b00 : 2'b10, id: id});
            if (burst == 2'b01) idx = (idx + 1) % DEPTH;
        end
    endtask

    task automatic collect_r(input int beats, input bit stall);
        r_exp_t e;
        for (int i = 0; i < beats; i++) begin
            int n = 0;
            while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
            checks++;
            if (n >= 50) begin errors++; $display("FAIL r_timeout beat %0d rvalid stayed 0", i); end
            e = rq.pop_front();
            if (stall && (i % 2 == 1)) begin
                @(negedge clk);
                checks++;
                if ({bus.rvalid, bus.rdata, bus.rlast, bus.rresp} !== {1'b1, e.data, e.last, e.resp}) begin
                    errors++;
                    $display("FAIL r_stall beat %0d got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             i, bus.rvalid, bus.rdata, bus.rlast, 1'b1, e.data, e.last);
                end
            end
            checks++;
            if ({bus.rdata, bus.rlast, bus.rresp, bus.rid} !== {e.data, e.last, e.resp, e.id}) begin
                errors++;
                $display("FAIL r_beat %0d got data=%h last=%b resp=%b id=%h, required data=%h last=%b resp=%b id=%h",
                         i, bus.rdata, bus.rlast, bus.rresp, bus.rid, e.data, e.last, e.resp, e.id);
            end
            bus.rready = 1;
            @(negedge clk);
            bus.rready = 0;
        end
        checks++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
            errors++;
            $display("FAIL r_end got rvalid=%b arready=%b, required rvalid=0 arready=1", bus.rvalid, bus.arready);
        end
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                              input logic [1:0] burst, input bit stall);
        push_r(addr, id, len, burst, 3'd3);
        do_ar(addr, id, len, burst, 3'd3);
        collect_r(int'(len) + 1, stall);
    endtask

    task automatic check_idle_outputs(input string tag, input logic rdy);
        checks++;
        if ({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp,
             bus.rlast, bus.bid, bus.rid, bus.rdata} !== {rdy, rdy, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
             1'b0, 4'h0, 4'h0, 64'h0}) begin
            errors++;
            $display("FAIL %s got awready=%b arready=%b wready=%b bvalid=%b rvalid=%b rdata=%h, required readys=%b others 0",
                     tag, bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rdata, rdy);
        end
    endtask

    task automatic test_reset();
        init_bus();
        rst_n = 0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state", 1'b0);
        rst_n = 1;
        @(negedge clk);
        check_idle_outputs("after_release", 1'b1);
    endtask

    task automatic test_single();
        wd[0] = 64'hDEADBEEF_CAFEF00D; ws[0] = 8'hFF;
        write_burst(32'h10, 4'h1, 8'd0, 2'b01, 3'd3, -1);
        checks++;
        if (bus.bvalid !== 1'b1) begin
            errors++;
            $display("FAIL b_latency bvalid=%b two cycles after AW, required 1", bus.bvalid);
        end
        collect_b(0);
        read_burst(32'h10, 4'h2, 8'd0, 2'b01, 0);
    endtask

    task automatic test_strobe();
        wd[0] = 64'h11223344_55667788; ws[0] = 8'hFF;
        write_burst(32'h20, 4'h3, 8'd0, 2'b01, 3'd3, -1);
        collect_b(0);
        wd[0] = 64'hAAAAAAAA_BBBBBBBB; ws[0] = 8'h0F;
        write_burst(32'h20, 4'h3, 8'd0, 2'b01, 3'd3, -1);
        collect_b(0);
        read_burst(32'h20, 4'h3, 8'd0, 2'b01, 0);
    endtask

    task automatic test_bursts();
        for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
        write_burst(32'h0, 4'h1, 8'd3, 2'b01, 3'd3, -1);
        collect_b(0);
        read_burst(32'h0, 4'h1, 8'd3, 2'b01, 1);
        wd[0] = 64'hA; wd[1] = 64'hB; wd[2] = 64'hC;
        write_burst(32'h80, 4'h6, 8'd2, 2'b00, 3'd3, -1);
        collect_b(0);
        read_burst(32'h80, 4'h6, 8'd0, 2'b01, 0);
        read_burst(32'h88, 4'h6, 8'd0, 2'b01, 0);
    endtask

    task automatic test_early_wlast();
        wd[0] = 64'h1111; wd[1] = 64'h2222; ws[0] = 8'hFF; ws[1] = 8'hFF;
        write_burst(32'h40, 4'h3, 8'd1, 2'b01, 3'd3, 0);
        collect_b(3);
    endtask

    task automatic test_wrap_and_alias();
        read_burst(32'h0, 4'h5, 8'd1, 2'b10, 0);
        wd[0] = 64'hFFFF; ws[0] = 8'hFF;
        write_burst(32'h18, 4'h7, 8'd0, 2'b10, 3'd3, -1);
        collect_b(0);
        read_burst(32'h18, 4'h7, 8'd0, 2'b01, 0);
        read_burst(32'(DEPTH * 8), 4'h8, 8'd0, 2'b01, 0);
    endtask

    task automatic test_concurrent();
        wd[0] = 64'h55; ws[0] = 8'hFF;
        write_burst(32'h28, 4'h9, 8'd0, 2'b01, 3'd3, -1);
        collect_b(0);
        do_aw(32'h28, 4'h9, 8'd0, 2'b01, 3'd3);
        push_r(32'h28, 4'hA, 8'd0, 2'b01, 3'd3);
        checks++;
        if (bus.wready !== 1'b1 || bus.arready !== 1'b1) begin
            errors++;
            $display("FAIL concurrent_ready got wready=%b arready=%b, required both 1", bus.wready, bus.arready);
        end
        bus.araddr = 32'h28; bus.arid = 4'hA; bus.arlen = 8'd0; bus.arburst = 2'b01; bus.arsize = 3'd3;
        bus.arvalid = 1;
        bus.wdata = 64'h66; bus.wstrb = 8'hFF; bus.wlast = 1; bus.wvalid = 1;
        @(negedge clk);
        bus.arvalid = 0; bus.wvalid = 0;
        model_write(5, 64'h66, 8'hFF);
        bq.push_back('{id: 4'h9, resp: 2'b00});
        collect_r(1, 0);
        collect_b(0);
        read_burst(32'h28, 4'hA, 8'd0, 2'b01, 0);
    endtask

    task automatic test_reset_mid_burst();
        wd[0] = 64'h1200; wd[1] = 64'h1300;
        do_aw(32'h60, 4'h2, 8'd3, 2'b01, 3'd3);
        do_w(wd[0], 8'hFF, 1'b0);
        do_w(wd[1], 8'hFF, 1'b0);
        model_write(12, wd[0], 8'hFF);
        model_write(13, wd[1], 8'hFF);
        rst_n = 0;
        #1;
        check_idle_outputs("mid_reset", 1'b0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check_idle_outputs("mid_release", 1'b1);
        read_burst(32'h60, 4'h4, 8'd1, 2'b01, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_strobe();
        test_bursts();
        test_early_wlast();
        test_wrap_and_alias();
        test_concurrent();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
